// File: rtl/pattern_line_sequencer.sv
// Line/frame timing source: emits pixels row-major over valid/ready,
// pulses newLine after each line and endFrame once per completed frame.
module pattern_line_sequencer #(
    parameter int PIXELS_PER_LINE = 32,
    parameter int LINES_PER_FRAME = 24,
    parameter int HBLANK          = 4,
    parameter int COL_W           = 5,
    parameter int ROW_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             start,
    input  logic             pixel_ready,
    output logic             pixel_valid,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             newLine,
    output logic             endFrame,
    output logic             busy
);

    localparam int HB_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIXELS_PER_LINE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES_PER_FRAME - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HBLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_FRAME_END
    } state_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col_nxt;
    logic [ROW_W-1:0]  row_nxt;
    logic [HB_W-1:0]   hb_cnt, hb_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            col    <= '0;
            row    <= '0;
            hb_cnt <= '0;
        end else begin
            state  <= state_nxt;
            col    <= col_nxt;
            row    <= row_nxt;
            hb_cnt <= hb_nxt;
        end
    end

    // enb low overrides every transition, including the last-pixel accept
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        hb_nxt    = hb_cnt;
        if (!enb) begin
            state_nxt = S_IDLE;
            col_nxt   = '0;
            row_nxt   = '0;
            hb_nxt    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_ACTIVE;
                        col_nxt   = '0;
                        row_nxt   = '0;
                    end
                end
                S_ACTIVE: begin
                    if (pixel_valid && pixel_ready) begin
                        if (col == COL_LAST) begin
                            col_nxt   = '0;
                            hb_nxt    = '0;
                            state_nxt = S_HBLANK;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end
                end
                S_HBLANK: begin
                    hb_nxt = hb_cnt + 1'b1;
                    if (hb_cnt == HB_LAST) begin
                        hb_nxt = '0;
                        if (row == ROW_LAST) begin
                            state_nxt = S_FRAME_END;
                        end else begin
                            row_nxt   = row + 1'b1;
                            state_nxt = S_ACTIVE;
                        end
                    end
                end
                S_FRAME_END: begin
                    state_nxt = S_IDLE;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign pixel_valid = (state == S_ACTIVE);
    assign newLine     = (state == S_HBLANK) && (hb_cnt == '0);
    assign endFrame    = (state == S_FRAME_END);
    assign busy        = (state != S_IDLE);

endmodule
